// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM states,
// port-select codes and default memory geometry.
package mem_arbiter_pkg;

    localparam int DEFAULT_ADDR_W = 10;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        STOP  = 2'd2
    } arb_state_e;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_I    = 2'b01;
    localparam logic [1:0] SEL_D    = 2'b10;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant decision: data port wins by default, unless the
// starvation flag says the instruction port has waited long enough.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       enable,
    input  logic       i_req,
    input  logic       d_req,
    input  logic       starve_hit,
    output logic [1:0] sel
);

    always_comb begin
        sel = SEL_NONE;
        if (enable) begin
            if (d_req && !(starve_hit && i_req)) begin
                sel = SEL_D;
            end else if (i_req) begin
                sel = SEL_I;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (I fetch / D load-store) arbiter for a single-port synchronous RAM
// with halt drain. Define MEM_ARB_STARVE_GUARD_EN to build the I-starvation guard.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int STARVE_LIMIT = 4
)(
    input  logic              clk1,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    input  logic              halt_req,
    output logic              halt_ack
);

    arb_state_e        state_reg;
    logic              i_rvalid_reg;
    logic              d_rvalid_reg;
    logic              halt_ack_reg;
    logic [DATA_W-1:0] rdata_reg;

    logic              grant_en;
    logic              starve_hit;
    logic              rd_pending;
    logic [1:0]        sel;

    // Grants are only issued in RUN and never during the reset cycle.
    assign grant_en = (state_reg == RUN) && !rst;

    mem_arb_pick u_pick (
        .enable     (grant_en),
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_hit (starve_hit),
        .sel        (sel)
    );

    assign i_gnt      = (sel == SEL_I);
    assign d_gnt      = (sel == SEL_D);
    assign mem_en     = i_gnt | d_gnt;
    assign mem_we     = d_gnt & d_we;
    assign mem_addr   = d_gnt ? d_addr : i_addr;
    assign mem_wdata  = d_wdata;
    assign rd_pending = i_gnt | (d_gnt & ~d_we);

    // A reset landing on the return cycle kills the response outright.
    assign i_rvalid = i_rvalid_reg & ~rst;
    assign d_rvalid = d_rvalid_reg & ~rst;
    assign rdata    = (i_rvalid_reg | d_rvalid_reg) ? mem_rdata : rdata_reg;
    assign halt_ack = halt_ack_reg;

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_reg    <= RUN;
            i_rvalid_reg <= 1'b0;
            d_rvalid_reg <= 1'b0;
            halt_ack_reg <= 1'b0;
            rdata_reg    <= '0;
        end else begin
            i_rvalid_reg <= i_gnt;
            d_rvalid_reg <= d_gnt & ~d_we;
            if (i_rvalid_reg | d_rvalid_reg) begin
                rdata_reg <= mem_rdata;
            end
            case (state_reg)
                RUN: begin
                    if (halt_req) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!rd_pending) begin
                        state_reg    <= STOP;
                        halt_ack_reg <= 1'b1;
                    end
                end
                STOP: begin
                    halt_ack_reg <= 1'b1;
                end
                default: begin
                    state_reg <= RUN;
                end
            endcase
        end
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_reg;

    assign starve_hit = (starve_cnt_reg == CNT_W'(STARVE_LIMIT));

    // Counts D grants that I sat through; any I grant or I withdrawing resets it.
    always_ff @(posedge clk1) begin
        if (rst || i_gnt || !i_req) begin
            starve_cnt_reg <= '0;
        end else if (d_gnt && !starve_hit) begin
            starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
        end
    end
`else
    // Pure fixed priority: the limit can never be reached.
    assign starve_hit = (STARVE_LIMIT < 0);
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width of the shared 1024 x 32 memory.
REQ-002 SHALL have parameter DATA_W, default 32, memory word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, maximum consecutive D grants while I is waiting (used only under REQ-027).
REQ-004 SHALL have port clk1  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports i_req  input  1, i_addr  input  ADDR_W, i_gnt  output  1, i_rvalid  output  1: instruction-fetch requester, read-only.
REQ-007 SHALL have ports d_req  input  1, d_we  input  1, d_addr  input  ADDR_W, d_wdata  input  DATA_W, d_gnt  output  1, d_rvalid  output  1: load/store requester.
REQ-008 SHALL have port rdata  output  DATA_W  read data shared by both ports, qualified by i_rvalid or d_rvalid.
REQ-009 SHALL have ports mem_en  output  1, mem_we  output  1, mem_addr  output  ADDR_W, mem_wdata  output  DATA_W, mem_rdata  input  DATA_W: single memory port with one-cycle registered read.
REQ-010 SHALL have ports halt_req  input  1 (HLT reached write-back) and halt_ack  output  1 (arbiter quiescent).

Function
REQ-011 Grant SHALL be combinational: at most one of i_gnt, d_gnt is high in any cycle.
REQ-012 A granted transfer SHALL complete in its grant cycle: mem_en=1, mem_addr/mem_we/mem_wdata taken from the granted port; mem_we=0 for I.
REQ-013 With no grant, mem_en and mem_we SHALL be 0; mem_addr and mem_wdata are don't-care.
REQ-014 Requesters hold req/addr/data stable until gnt; the cycle after gnt they may re-request, and back-to-back grants to one port SHALL be legal.
REQ-015 For a granted read, the matching rvalid SHALL pulse exactly one cycle after gnt, with rdata = mem_rdata; a granted write SHALL produce no rvalid.
REQ-016 Default priority SHALL be fixed: d_req beats i_req.
REQ-017 FSM states SHALL be RUN, DRAIN, STOP.
REQ-018 RUN: grants per REQ-016; halt_req=1 moves to DRAIN on the next edge, and the cycle of that edge's decision still grants normally.
REQ-019 DRAIN: no grants; moves to STOP once no rvalid is pending for the next cycle (DRAIN lasts exactly one cycle).
REQ-020 STOP: no grants, halt_ack=1; leaves STOP only on rst.
REQ-021 halt_req while already in DRAIN or STOP SHALL be ignored.
REQ-022 Requests arriving in DRAIN/STOP SHALL receive no gnt and have no side effect.

Reset
REQ-023 rst SHALL force state RUN, i_rvalid=0, d_rvalid=0, halt_ack=0, starvation counter 0, rdata register 0.
REQ-024 During the rst cycle i_gnt, d_gnt, mem_en, mem_we SHALL be 0 regardless of requests.
REQ-025 rst asserted in the cycle after a grant SHALL suppress that grant's rvalid.

Configuration
REQ-026 Macro MEM_ARB_STARVE_GUARD_EN SHALL select the starvation guard.
REQ-027 With the macro defined: a counter SHALL increment on each d_gnt while i_req=1, and clear on i_gnt or when i_req=0; when it equals STARVE_LIMIT, I SHALL win the next contended cycle, then the counter clears.
REQ-028 Without the macro: pure fixed priority per REQ-016; no counter logic synthesised.

Structure
REQ-029 The shared package SHALL hold FSM state enum (RUN, DRAIN, STOP), port-select constants, and default ADDR_W/DATA_W.
REQ-030 The priority/starvation decision SHALL be a combinational sub-module mem_arb_pick; FSM and rvalid pipeline stay in mem_arbiter.

Verification
REQ-031 i_req=1, i_addr=5, d_req=0 -> i_gnt=1, mem_addr=5, mem_we=0; next cycle i_rvalid=1, rdata=Mem[5].
REQ-032 d_req=1 d_we=1 d_addr=10 d_wdata=0xDEADBEEF with i_req=1 -> d_gnt=1, i_gnt=0, mem_we=1; no rvalid; later I read of 10 returns 0xDEADBEEF.
REQ-033 Guard enabled, STARVE_LIMIT=4, i_req and d_req held high 6 cycles -> d_gnt for 4 cycles, i_gnt on the 5th, d_gnt on the 6th.
REQ-034 D read granted in cycle N with halt_req=1 in cycle N -> d_rvalid at N+1 (DRAIN), halt_ack=1 from N+2, no gnt from N+1 despite pending requests.
REQ-035 rst in cycle after an I grant -> i_rvalid=0; state RUN, halt_ack=0 next cycle.
